// File: rtl/conv_tile_sched.sv
// conv_tile_sched: runtime-configurable convolution tile scheduler.
//
// Walks one tile as nested loops (tap j -> tap i -> out col -> out row ->
// slice -> block). Each issuing cycle produces registered in_fm/weight read
// addresses. Every finished kernel schedules an out_fm read-modify-write
// through a fixed-latency delay line that models the accumulator pipeline.
//
// Optional feature macro: CONV_TILE_PERF_EN adds perf_stall_cnt/perf_run_cnt.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   start, ena            start pulse (IDLE only), issue enable
//   cfg_k, cfg_s          kernel size, stride (1..15)
//   cfg_tr, cfg_tc        input tile rows / cols
//   cfg_slice_num         slices per block
//   cfg_block_num         blocks per tile
//   busy, cfg_err         tile in flight, rejected-start pulse
//   kernel_start/_done    first / last tap of a kernel issued
//   in_fm_rd_addr/_vld    input feature-map read address and valid
//   weight_rd_addr        weight read address (shares in_fm_rd_vld)
//   out_fm_rd_addr/_ena   output feature-map read
//   out_fm_first          read belongs to slice 0 (accumulate onto zero)
//   out_fm_wr_addr/_ena   output feature-map write
//   conv_done             one-cycle tile completion pulse
//   perf_stall_cnt        (CONV_TILE_PERF_EN) RUN cycles with ena low
//   perf_run_cnt          (CONV_TILE_PERF_EN) cycles with busy high
module conv_tile_sched #(
    parameter int unsigned AW        = 16,
    parameter int unsigned CW        = 8,
    parameter int unsigned ACC_DELAY = 71,
    parameter int unsigned RMW_DELAY = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          ena,
    input  logic [3:0]    cfg_k,
    input  logic [3:0]    cfg_s,
    input  logic [CW-1:0] cfg_tr,
    input  logic [CW-1:0] cfg_tc,
    input  logic [CW-1:0] cfg_slice_num,
    input  logic [CW-1:0] cfg_block_num,
    output logic          busy,
    output logic          cfg_err,
    output logic          kernel_start,
    output logic          kernel_done,
    output logic [AW-1:0] in_fm_rd_addr,
    output logic          in_fm_rd_vld,
    output logic [AW-1:0] weight_rd_addr,
    output logic [AW-1:0] out_fm_rd_addr,
    output logic          out_fm_rd_ena,
    output logic          out_fm_first,
    output logic [AW-1:0] out_fm_wr_addr,
    output logic          out_fm_wr_ena,
    output logic          conv_done
`ifdef CONV_TILE_PERF_EN
    ,
    output logic [31:0]   perf_stall_cnt,
    output logic [31:0]   perf_run_cnt
`endif
);

    localparam int unsigned PW         = 32;
    localparam int unsigned DRAIN_LAST = ACC_DELAY + RMW_DELAY;

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e        state_q;
    logic [3:0]    k_q, s_q;
    logic [CW-1:0] tc_q, slice_num_q, block_num_q, oh_q, ow_q;
    logic [3:0]    j_q, i_q;
    logic [CW-1:0] ocol_q, orow_q, slice_q, block_q;
    logic [15:0]   drain_q;

    logic          cfg_bad;
    logic [CW-1:0] oh_new, ow_new;
    logic          issue, last_j, last_i, last_ocol, last_orow, last_slice, last_block;
    logic          k_first, k_last;
    logic [AW-1:0] in_addr_w, w_addr_w, o_addr_w;

    always_comb begin
        cfg_bad = (cfg_k == 4'd0) || (cfg_s == 4'd0) ||
                  (cfg_tr < CW'(cfg_k)) || (cfg_tc < CW'(cfg_k)) ||
                  (cfg_slice_num == '0) || (cfg_block_num == '0);
        oh_new  = '0;
        ow_new  = '0;
        // Division only for legal configs, so a zero stride never reaches the divider.
        if (!cfg_bad) begin
            oh_new = (cfg_tr - CW'(cfg_k)) / CW'(cfg_s) + CW'(1);
            ow_new = (cfg_tc - CW'(cfg_k)) / CW'(cfg_s) + CW'(1);
        end
    end

    always_comb begin
        issue      = (state_q == StRun) && ena;
        last_j     = (j_q == k_q - 4'd1);
        last_i     = (i_q == k_q - 4'd1);
        last_ocol  = (ocol_q == ow_q - CW'(1));
        last_orow  = (orow_q == oh_q - CW'(1));
        last_slice = (slice_q == slice_num_q - CW'(1));
        last_block = (block_q == block_num_q - CW'(1));
        k_first    = issue && (j_q == 4'd0) && (i_q == 4'd0);
        k_last     = issue && last_j && last_i;
    end

    // Products formed at 32 bits, then truncated to the buffer address width.
    always_comb begin
        in_addr_w = AW'((PW'(orow_q) * PW'(s_q) + PW'(i_q)) * PW'(tc_q) +
                        PW'(ocol_q) * PW'(s_q) + PW'(j_q));
        w_addr_w  = AW'((PW'(block_q) * PW'(slice_num_q) + PW'(slice_q)) * PW'(k_q) * PW'(k_q) +
                        PW'(i_q) * PW'(k_q) + PW'(j_q));
        o_addr_w  = AW'(PW'(block_q) * PW'(oh_q) * PW'(ow_q) + PW'(orow_q) * PW'(ow_q) +
                        PW'(ocol_q));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= StIdle;
            k_q            <= '0;
            s_q            <= '0;
            tc_q           <= '0;
            slice_num_q    <= '0;
            block_num_q    <= '0;
            oh_q           <= '0;
            ow_q           <= '0;
            j_q            <= '0;
            i_q            <= '0;
            ocol_q         <= '0;
            orow_q         <= '0;
            slice_q        <= '0;
            block_q        <= '0;
            drain_q        <= '0;
            busy           <= 1'b0;
            cfg_err        <= 1'b0;
            conv_done      <= 1'b0;
            in_fm_rd_vld   <= 1'b0;
            in_fm_rd_addr  <= '0;
            weight_rd_addr <= '0;
            kernel_start   <= 1'b0;
            kernel_done    <= 1'b0;
        end else begin
            cfg_err      <= 1'b0;
            conv_done    <= 1'b0;
            in_fm_rd_vld <= 1'b0;
            kernel_start <= 1'b0;
            kernel_done  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        if (cfg_bad) begin
                            cfg_err <= 1'b1;
                        end else begin
                            k_q         <= cfg_k;
                            s_q         <= cfg_s;
                            tc_q        <= cfg_tc;
                            slice_num_q <= cfg_slice_num;
                            block_num_q <= cfg_block_num;
                            oh_q        <= oh_new;
                            ow_q        <= ow_new;
                            j_q         <= '0;
                            i_q         <= '0;
                            ocol_q      <= '0;
                            orow_q      <= '0;
                            slice_q     <= '0;
                            block_q     <= '0;
                            busy        <= 1'b1;
                            state_q     <= StRun;
                        end
                    end
                end
                StRun: begin
                    if (ena) begin
                        in_fm_rd_vld   <= 1'b1;
                        in_fm_rd_addr  <= in_addr_w;
                        weight_rd_addr <= w_addr_w;
                        kernel_start   <= k_first;
                        kernel_done    <= k_last;
                        if (!last_j) begin
                            j_q <= j_q + 4'd1;
                        end else begin
                            j_q <= '0;
                            if (!last_i) begin
                                i_q <= i_q + 4'd1;
                            end else begin
                                i_q <= '0;
                                if (!last_ocol) begin
                                    ocol_q <= ocol_q + CW'(1);
                                end else begin
                                    ocol_q <= '0;
                                    if (!last_orow) begin
                                        orow_q <= orow_q + CW'(1);
                                    end else begin
                                        orow_q <= '0;
                                        if (!last_slice) begin
                                            slice_q <= slice_q + CW'(1);
                                        end else begin
                                            slice_q <= '0;
                                            if (!last_block) begin
                                                block_q <= block_q + CW'(1);
                                            end else begin
                                                block_q <= '0;
                                                drain_q <= '0;
                                                state_q <= StDrain;
                                            end
                                        end
                                    end
                                end
                            end
                        end
                    end
                end
                StDrain: begin
                    // Hold until the last kernel's write has left the delay line.
                    if (drain_q == 16'(DRAIN_LAST)) begin
                        conv_done <= 1'b1;
                        busy      <= 1'b0;
                        state_q   <= StDone;
                    end else begin
                        drain_q <= drain_q + 16'd1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Accumulator-latency and read-modify-write delay lines; they run free of ena.
    logic [ACC_DELAY-1:0] acc_vld_q, acc_first_q;
    logic [AW-1:0]        acc_addr_q [ACC_DELAY];
    logic [RMW_DELAY-1:0] rmw_vld_q;
    logic [AW-1:0]        rmw_addr_q [RMW_DELAY];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_vld_q   <= '0;
            acc_first_q <= '0;
            rmw_vld_q   <= '0;
            for (int n = 0; n < ACC_DELAY; n++) acc_addr_q[n] <= '0;
            for (int n = 0; n < RMW_DELAY; n++) rmw_addr_q[n] <= '0;
        end else begin
            acc_vld_q[0]   <= k_last;
            acc_first_q[0] <= k_last && (slice_q == '0);
            acc_addr_q[0]  <= k_last ? o_addr_w : '0;
            for (int n = 1; n < ACC_DELAY; n++) begin
                acc_vld_q[n]   <= acc_vld_q[n-1];
                acc_first_q[n] <= acc_first_q[n-1];
                acc_addr_q[n]  <= acc_addr_q[n-1];
            end
            rmw_vld_q[0]  <= acc_vld_q[ACC_DELAY-1];
            rmw_addr_q[0] <= acc_addr_q[ACC_DELAY-1];
            for (int n = 1; n < RMW_DELAY; n++) begin
                rmw_vld_q[n]  <= rmw_vld_q[n-1];
                rmw_addr_q[n] <= rmw_addr_q[n-1];
            end
        end
    end

    assign out_fm_rd_ena  = acc_vld_q[ACC_DELAY-1];
    assign out_fm_first   = acc_first_q[ACC_DELAY-1];
    assign out_fm_rd_addr = acc_addr_q[ACC_DELAY-1];
    assign out_fm_wr_ena  = rmw_vld_q[RMW_DELAY-1];
    assign out_fm_wr_addr = rmw_addr_q[RMW_DELAY-1];

`ifdef CONV_TILE_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_cnt <= '0;
            perf_run_cnt   <= '0;
        end else if ((state_q == StIdle) && start && !cfg_bad) begin
            perf_stall_cnt <= '0;
            perf_run_cnt   <= '0;
        end else begin
            if ((state_q == StRun) && !ena && (perf_stall_cnt != '1)) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
            if (busy && (perf_run_cnt != '1)) begin
                perf_run_cnt <= perf_run_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_conv_tile_sched.sv
// Self-checking bench for conv_tile_sched. Expected addresses are pushed by a
// loop-nest model when a tile is launched; a negedge monitor records what the
// DUT emits, and each test task compares the two after conv_done.
module tb_conv_tile_sched;
    localparam int AW = 16;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst, start, ena;
    logic [3:0]    cfg_k, cfg_s;
    logic [CW-1:0] cfg_tr, cfg_tc, cfg_slice_num, cfg_block_num;
    logic          busy, cfg_err, kernel_start, kernel_done;
    logic [AW-1:0] in_fm_rd_addr, weight_rd_addr, out_fm_rd_addr, out_fm_wr_addr;
    logic          in_fm_rd_vld, out_fm_rd_ena, out_fm_first, out_fm_wr_ena, conv_done;
`ifdef CONV_TILE_PERF_EN
    logic [31:0]   perf_stall_cnt, perf_run_cnt;
`endif

    conv_tile_sched dut (
        .clk(clk), .rst(rst), .start(start), .ena(ena),
        .cfg_k(cfg_k), .cfg_s(cfg_s), .cfg_tr(cfg_tr), .cfg_tc(cfg_tc),
        .cfg_slice_num(cfg_slice_num), .cfg_block_num(cfg_block_num),
        .busy(busy), .cfg_err(cfg_err), .kernel_start(kernel_start),
        .kernel_done(kernel_done), .in_fm_rd_addr(in_fm_rd_addr),
        .in_fm_rd_vld(in_fm_rd_vld), .weight_rd_addr(weight_rd_addr),
        .out_fm_rd_addr(out_fm_rd_addr), .out_fm_rd_ena(out_fm_rd_ena),
        .out_fm_first(out_fm_first), .out_fm_wr_addr(out_fm_wr_addr),
        .out_fm_wr_ena(out_fm_wr_ena), .conv_done(conv_done)
`ifdef CONV_TILE_PERF_EN
        , .perf_stall_cnt(perf_stall_cnt), .perf_run_cnt(perf_run_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    // Scoreboard: expected (pushed at launch) and observed (pushed by monitor).
    logic [AW-1:0] exp_in[$], exp_w[$], exp_rd[$];
    logic          exp_first[$];
    logic [AW-1:0] obs_in[$], obs_w[$], obs_rd[$], obs_wr[$];
    logic          obs_first[$];
    int            obs_rd_cyc[$], obs_wr_cyc[$], obs_err_cyc[$], obs_done_cyc[$];
    int            obs_ks_cyc[$], obs_kd_cyc[$];
    int            p_in = 0, p_rd = 0, p_wr = 0, p_ks = 0, p_kd = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (in_fm_rd_vld) begin
                obs_in.push_back(in_fm_rd_addr);
                obs_w.push_back(weight_rd_addr);
            end
            if (kernel_start) obs_ks_cyc.push_back(cyc);
            if (kernel_done) obs_kd_cyc.push_back(cyc);
            if (out_fm_rd_ena) begin
                obs_rd.push_back(out_fm_rd_addr);
                obs_first.push_back(out_fm_first);
                obs_rd_cyc.push_back(cyc);
            end
            if (out_fm_wr_ena) begin
                obs_wr.push_back(out_fm_wr_addr);
                obs_wr_cyc.push_back(cyc);
            end
            if (cfg_err) obs_err_cyc.push_back(cyc);
            if (conv_done) obs_done_cyc.push_back(cyc);
        end
    end

    task automatic set_cfg(input int k, input int s, input int tr, input int tc,
                           input int sn, input int bn);
        cfg_k = 4'(k); cfg_s = 4'(s); cfg_tr = CW'(tr); cfg_tc = CW'(tc);
        cfg_slice_num = CW'(sn); cfg_block_num = CW'(bn);
    endtask

    task automatic gen_expected(input int k, input int s, input int tr, input int tc,
                                input int sn, input int bn);
        int oh, ow;
        oh = (tr - k) / s + 1;
        ow = (tc - k) / s + 1;
        for (int b = 0; b < bn; b++)
            for (int sl = 0; sl < sn; sl++)
                for (int r = 0; r < oh; r++)
                    for (int c = 0; c < ow; c++) begin
                        for (int i = 0; i < k; i++)
                            for (int j = 0; j < k; j++) begin
                                exp_in.push_back(AW'((r * s + i) * tc + c * s + j));
                                exp_w.push_back(AW'((b * sn + sl) * k * k + i * k + j));
                            end
                        exp_rd.push_back(AW'(b * oh * ow + r * ow + c));
                        exp_first.push_back(sl == 0);
                    end
    endtask

    task automatic resync();
        p_in = obs_in.size(); p_rd = obs_rd.size(); p_wr = obs_wr.size();
        p_ks = obs_ks_cyc.size(); p_kd = obs_kd_cyc.size();
        exp_in.delete(); exp_w.delete(); exp_rd.delete(); exp_first.delete();
    endtask

    // Launch the latched cfg and wait (bounded) for conv_done.
    task automatic run_tile(input string tag, input bit toggle, input int poke,
                            output int acc, output int dn);
        logic [3:0] k_save;
        k_save = cfg_k;
        @(posedge clk); #1; start = 1'b1; ena = 1'b1;
        @(posedge clk); #1; acc = cyc; start = 1'b0;
        dn = -1;
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            if (conv_done) begin dn = cyc; break; end
            @(posedge clk); #1;
            if (toggle) ena = ~ena;
            start = (n == poke);
            cfg_k = (n == poke) ? 4'd2 : k_save;
        end
        ena = 1'b1; start = 1'b0; cfg_k = k_save;
        n_vec++;
        if (dn < 0) begin
            n_err++;
            $display("FAIL %s conv_done_timeout got none want pulse", tag);
        end
    endtask

    task automatic drain_scoreboard(input string tag);
        int nt, nk;
        nt = exp_in.size();
        nk = exp_rd.size();
        n_vec++;
        if (obs_in.size() - p_in !== nt) begin
            n_err++; $display("FAIL %s vld_count got %0d want %0d", tag, obs_in.size() - p_in, nt);
        end
        n_vec++;
        if (obs_rd.size() - p_rd !== nk) begin
            n_err++; $display("FAIL %s rd_count got %0d want %0d", tag, obs_rd.size() - p_rd, nk);
        end
        n_vec++;
        if (obs_wr.size() - p_wr !== nk) begin
            n_err++; $display("FAIL %s wr_count got %0d want %0d", tag, obs_wr.size() - p_wr, nk);
        end
        n_vec++;
        if (obs_ks_cyc.size() - p_ks !== nk) begin
            n_err++;
            $display("FAIL %s kstart_count got %0d want %0d", tag, obs_ks_cyc.size() - p_ks, nk);
        end
        n_vec++;
        if (obs_kd_cyc.size() - p_kd !== nk) begin
            n_err++;
            $display("FAIL %s kdone_count got %0d want %0d", tag, obs_kd_cyc.size() - p_kd, nk);
        end
        for (int t = 0; t < nt; t++) begin
            if (p_in + t >= obs_in.size()) break;
            n_vec++;
            if (obs_in[p_in+t] !== exp_in[t]) begin
                n_err++;
                $display("FAIL %s in_fm_rd_addr[%0d] got %0d want %0d", tag, t, obs_in[p_in+t],
                         exp_in[t]);
            end
            n_vec++;
            if (obs_w[p_in+t] !== exp_w[t]) begin
                n_err++;
                $display("FAIL %s weight_rd_addr[%0d] got %0d want %0d", tag, t, obs_w[p_in+t],
                         exp_w[t]);
            end
        end
        for (int q = 0; q < nk; q++) begin
            if (p_rd + q < obs_rd.size()) begin
                n_vec++;
                if (obs_rd[p_rd+q] !== exp_rd[q] || obs_first[p_rd+q] !== exp_first[q]) begin
                    n_err++;
                    $display("FAIL %s out_fm_rd[%0d] got addr %0d first %0b want %0d %0b", tag, q,
                             obs_rd[p_rd+q], obs_first[p_rd+q], exp_rd[q], exp_first[q]);
                end
                // kernel_done trails its issue by one, the read by ACC_DELAY.
                if (p_kd + q < obs_kd_cyc.size()) begin
                    n_vec++;
                    if (obs_rd_cyc[p_rd+q] - obs_kd_cyc[p_kd+q] !== 70) begin
                        n_err++;
                        $display("FAIL %s rd_latency[%0d] got %0d want 70", tag, q,
                                 obs_rd_cyc[p_rd+q] - obs_kd_cyc[p_kd+q]);
                    end
                end
                if (p_wr + q < obs_wr.size()) begin
                    n_vec++;
                    if (obs_wr[p_wr+q] !== exp_rd[q] ||
                        obs_wr_cyc[p_wr+q] - obs_rd_cyc[p_rd+q] !== 2) begin
                        n_err++;
                        $display("FAIL %s out_fm_wr[%0d] got addr %0d gap %0d want %0d gap 2",
                                 tag, q, obs_wr[p_wr+q], obs_wr_cyc[p_wr+q] - obs_rd_cyc[p_rd+q],
                                 exp_rd[q]);
                    end
                end
            end
        end
        resync();
    endtask

    task automatic check_tile_timing(input string tag, input int acc, input int dn,
                                     input int want);
        n_vec++;
        if (dn - acc !== want) begin
            n_err++; $display("FAIL %s done_latency got %0d want %0d", tag, dn - acc, want);
        end
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++; $display("FAIL %s busy_at_done got %0b want 0", tag, busy);
        end
    endtask

    task automatic test_reset();
        n_vec++;
        if ({busy, cfg_err, kernel_start, kernel_done, in_fm_rd_vld, out_fm_rd_ena, out_fm_first,
             out_fm_wr_ena, conv_done} !== 9'b0) begin
            n_err++; $display("FAIL reset_strobes got nonzero want 0");
        end
        n_vec++;
        if ({in_fm_rd_addr, weight_rd_addr, out_fm_rd_addr, out_fm_wr_addr} !== '0) begin
            n_err++; $display("FAIL reset_addrs got nonzero want 0");
        end
`ifdef CONV_TILE_PERF_EN
        n_vec++;
        if (perf_stall_cnt !== 32'd0 || perf_run_cnt !== 32'd0) begin
            n_err++; $display("FAIL reset_perf got %0d %0d want 0 0", perf_stall_cnt, perf_run_cnt);
        end
`endif
    endtask

    task automatic test_basic(input string tag);
        int acc, dn, base;
        base = obs_in.size();
        set_cfg(3, 1, 5, 5, 1, 1);
        gen_expected(3, 1, 5, 5, 1, 1);
        run_tile(tag, 1'b0, -1, acc, dn);
        check_tile_timing(tag, acc, dn, 155);
        n_vec++;
        if (obs_in.size() <= base + 3 || obs_in[base+3] !== 16'd5) begin
            n_err++; $display("FAIL %s fourth_in_fm_addr got other want 5", tag);
        end
        drain_scoreboard(tag);
`ifdef CONV_TILE_PERF_EN
        n_vec++;
        if (perf_stall_cnt !== 32'd0 || perf_run_cnt !== 32'd155) begin
            n_err++;
            $display("FAIL %s perf got stall %0d run %0d want 0 155", tag, perf_stall_cnt,
                     perf_run_cnt);
        end
`endif
    endtask

    // Launched in the cycle right after the previous conv_done.
    task automatic test_back_to_back();
        int acc, dn, base;
        base = obs_in.size();
        set_cfg(3, 2, 7, 7, 1, 1);
        gen_expected(3, 2, 7, 7, 1, 1);
        run_tile("b2b_stride", 1'b0, -1, acc, dn);
        check_tile_timing("b2b_stride", acc, dn, 155);
        n_vec++;
        if (obs_in.size() <= base + 45 || obs_in[base+9] !== 16'd2 || obs_in[base+45] !== 16'd18)
        begin
            n_err++; $display("FAIL b2b_stride kernel_first_addrs got other want 2 and 18");
        end
        drain_scoreboard("b2b_stride");
    endtask

    task automatic test_multi();
        int acc, dn, base;
        base = obs_w.size();
        set_cfg(3, 1, 5, 5, 2, 2);
        gen_expected(3, 1, 5, 5, 2, 2);
        run_tile("multi", 1'b0, -1, acc, dn);
        check_tile_timing("multi", acc, dn, 398);
        n_vec++;
        if (obs_w.size() <= base + 243 || obs_w[base+243] !== 16'd27) begin
            n_err++; $display("FAIL multi b1s1_weight got other want 27");
        end
        drain_scoreboard("multi");
    endtask

    task automatic test_min_tile();
        int acc, dn;
        set_cfg(3, 1, 3, 3, 1, 1);
        gen_expected(3, 1, 3, 3, 1, 1);
        run_tile("min_tile", 1'b0, -1, acc, dn);
        check_tile_timing("min_tile", acc, dn, 83);
        drain_scoreboard("min_tile");
    endtask

    task automatic test_stall();
        int acc, dn;
        set_cfg(3, 1, 5, 5, 1, 1);
        gen_expected(3, 1, 5, 5, 1, 1);
        run_tile("stall", 1'b1, -1, acc, dn);
        check_tile_timing("stall", acc, dn, 235);
        drain_scoreboard("stall");
`ifdef CONV_TILE_PERF_EN
        n_vec++;
        if (perf_stall_cnt !== 32'd80 || perf_run_cnt !== 32'd235) begin
            n_err++;
            $display("FAIL stall perf got stall %0d run %0d want 80 235", perf_stall_cnt,
                     perf_run_cnt);
        end
`endif
    endtask

    task automatic test_cfg_err();
        int tbl[6][6] = '{'{3, 1, 2, 5, 1, 1}, '{0, 1, 5, 5, 1, 1}, '{3, 0, 5, 5, 1, 1},
                          '{3, 1, 5, 2, 1, 1}, '{3, 1, 5, 5, 0, 1}, '{3, 1, 5, 5, 1, 0}};
        int n_e, n_i, acc;
        for (int t = 0; t < 6; t++) begin
            set_cfg(tbl[t][0], tbl[t][1], tbl[t][2], tbl[t][3], tbl[t][4], tbl[t][5]);
            n_e = obs_err_cyc.size();
            n_i = obs_in.size();
            @(posedge clk); #1; start = 1'b1;
            @(posedge clk); #1; acc = cyc; start = 1'b0;
            repeat (4) @(negedge clk);
            n_vec++;
            if (obs_err_cyc.size() - n_e !== 1) begin
                n_err++;
                $display("FAIL cfg_err[%0d] pulse_count got %0d want 1", t, obs_err_cyc.size() - n_e);
            end else begin
                n_vec++;
                if (obs_err_cyc[n_e] !== acc) begin
                    n_err++;
                    $display("FAIL cfg_err[%0d] pulse_cycle got %0d want %0d", t, obs_err_cyc[n_e],
                             acc);
                end
            end
            n_vec++;
            if (busy !== 1'b0 || obs_in.size() !== n_i) begin
                n_err++;
                $display("FAIL cfg_err[%0d] busy_or_vld got busy %0b vld %0d want 0 0", t, busy,
                         obs_in.size() - n_i);
            end
        end
    endtask

    task automatic test_busy_start();
        int acc, dn;
        set_cfg(3, 1, 5, 5, 1, 1);
        gen_expected(3, 1, 5, 5, 1, 1);
        run_tile("busy_start", 1'b0, 20, acc, dn);
        check_tile_timing("busy_start", acc, dn, 155);
        drain_scoreboard("busy_start");
    endtask

    task automatic test_reset_mid();
        int n_w, n_r, n_i, n_d;
        set_cfg(3, 1, 5, 5, 2, 2);
        @(posedge clk); #1; start = 1'b1; ena = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (100) @(posedge clk);
        #1; rst = 1'b1;
        #1;
        n_vec++;
        if ({busy, in_fm_rd_vld, kernel_start, kernel_done, out_fm_rd_ena, out_fm_wr_ena,
             conv_done} !== 7'b0) begin
            n_err++; $display("FAIL reset_mid strobes got nonzero want 0");
        end
        n_vec++;
        if ({in_fm_rd_addr, weight_rd_addr, out_fm_rd_addr, out_fm_wr_addr} !== '0) begin
            n_err++; $display("FAIL reset_mid addrs got nonzero want 0");
        end
        @(posedge clk); #1; rst = 1'b0;
        n_w = obs_wr.size(); n_r = obs_rd.size(); n_i = obs_in.size(); n_d = obs_done_cyc.size();
        repeat (200) @(negedge clk);
        n_vec++;
        if (obs_wr.size() !== n_w || obs_rd.size() !== n_r) begin
            n_err++;
            $display("FAIL reset_mid stale_out_fm got %0d wr %0d rd want 0 0", obs_wr.size() - n_w,
                     obs_rd.size() - n_r);
        end
        n_vec++;
        if (obs_in.size() !== n_i || obs_done_cyc.size() !== n_d || busy !== 1'b0) begin
            n_err++; $display("FAIL reset_mid activity got vld/done/busy want none");
        end
        resync();
        test_basic("after_reset");
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; ena = 1'b0;
        set_cfg(0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        test_basic("basic");
        test_back_to_back();
        test_multi();
        test_min_tile();
        test_stall();
        test_cfg_err();
        test_busy_start();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
